// File: rtl/codec_scheduler.sv
// codec_scheduler: round-robin arbiter that time-shares one encoder/decoder
// between two requesters, holding each code on codec_in for SETTLE_CYCLES
// before capturing codec_out as the response.
// Optional self-test sweep compiled in with CODEC_SCHEDULER_SWEEP_EN.
module codec_scheduler #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [3:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_data,
  output logic       req1_ready,
  output logic       rsp_valid,
  output logic [3:0] rsp_data,
  output logic       rsp_id,
  input  logic       rsp_ready,
  output logic [3:0] codec_in,
  input  logic [3:0] codec_out,
  output logic       busy,
  input  logic       sweep_start,
  output logic       sweep_done,
  output logic       sweep_fail
);

`ifdef CODEC_SCHEDULER_SWEEP_EN
  typedef enum logic [1:0] {IDLE, DRIVE, RESPOND, SWEEP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DRIVE, RESPOND} state_t;
`endif

  // Index of the final settle cycle for one code.
  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     next_state;
  logic [3:0] settle_cnt;
  logic       settle_last;
  logic       last_grant;
  logic       grant_id;
  logic       accept;
  logic       sweep_go;

  assign settle_last = (settle_cnt == LAST_CNT);
  assign accept      = req0_ready | req1_ready;
  assign busy        = (state != IDLE);

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state, grant and ready decode.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    next_state = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    grant_id   = 1'b0;
    sweep_go   = 1'b0;
    case (state)
      IDLE: begin
`ifdef CODEC_SCHEDULER_SWEEP_EN
        if (sweep_start) begin
          sweep_go   = 1'b1;
          next_state = SWEEP;
        end else
`endif
        if (req0_valid || req1_valid) begin
          // Both valid: the one not granted last wins; else the lone valid.
          grant_id   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          next_state = DRIVE;
        end
      end
      DRIVE:   if (settle_last) next_state = RESPOND;
      RESPOND: if (rsp_ready)   next_state = IDLE;
`ifdef CODEC_SCHEDULER_SWEEP_EN
      SWEEP:   if (settle_last && codec_in == 4'hF) next_state = IDLE;
`endif
      default: next_state = IDLE;
    endcase
  end

  // Datapath: codec drive, settle counter, response capture, priority pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      codec_in   <= 4'h0;
      rsp_valid  <= 1'b0;
      rsp_data   <= 4'h0;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;
      settle_cnt <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          settle_cnt <= 4'h0;
          if (accept) begin
            codec_in <= grant_id ? req1_data : req0_data;
            rsp_id   <= grant_id;
          end else if (sweep_go) begin
            codec_in <= 4'h0;
          end
        end
        DRIVE: begin
          if (settle_last) begin
            rsp_data   <= codec_out;
            rsp_valid  <= 1'b1;
            settle_cnt <= 4'h0;
          end else begin
            settle_cnt <= settle_cnt + 4'h1;
          end
        end
        RESPOND: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            last_grant <= rsp_id;
          end
        end
`ifdef CODEC_SCHEDULER_SWEEP_EN
        SWEEP: begin
          if (settle_last) begin
            settle_cnt <= 4'h0;
            // Code 15 is the last one; the sweep never wraps back to 0.
            if (codec_in != 4'hF) codec_in <= codec_in + 4'h1;
          end else begin
            settle_cnt <= settle_cnt + 4'h1;
          end
        end
`endif
        default: settle_cnt <= 4'h0;
      endcase
    end
  end

`ifdef CODEC_SCHEDULER_SWEEP_EN
  // Self-test result flags: one-cycle done pulse and sticky mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_done <= 1'b0;
      sweep_fail <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      if (sweep_go) begin
        sweep_fail <= 1'b0;
      end else if (state == SWEEP && settle_last) begin
        if (codec_out != codec_in) sweep_fail <= 1'b1;
        if (codec_in == 4'hF)      sweep_done <= 1'b1;
      end
    end
  end
`else
  // Self-test not built: flags tied off, request input deliberately unused.
  logic unused_sweep_start;
  assign unused_sweep_start = sweep_start;
  assign sweep_done         = 1'b0;
  assign sweep_fail         = 1'b0;
`endif

endmodule

// File: tb/tb_codec_scheduler.sv
// Self-checking bench for codec_scheduler: directed scenarios plus a
// randomized run against a transaction-level timestamp model.
module tb_codec_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: SETTLE_CYCLES=1, codec can be made to corrupt code 4'hA.
  logic       a_v0, a_v1, a_r0, a_r1, a_rv, a_rid, a_rr, a_busy, a_ss, a_sd, a_sf;
  logic [3:0] a_d0, a_d1, a_rd, a_ci, a_co;
  logic       fault;
  assign a_co = (fault && a_ci == 4'hA) ? 4'h5 : a_ci;

  // Instance B: SETTLE_CYCLES=3, identity codec.
  logic       b_v0, b_v1, b_r0, b_r1, b_rv, b_rid, b_rr, b_busy, b_ss, b_sd, b_sf;
  logic [3:0] b_d0, b_d1, b_rd, b_ci, b_co;
  assign b_co = b_ci;

  codec_scheduler #(.SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(a_v0), .req0_data(a_d0), .req0_ready(a_r0),
    .req1_valid(a_v1), .req1_data(a_d1), .req1_ready(a_r1),
    .rsp_valid(a_rv), .rsp_data(a_rd), .rsp_id(a_rid), .rsp_ready(a_rr),
    .codec_in(a_ci), .codec_out(a_co), .busy(a_busy),
    .sweep_start(a_ss), .sweep_done(a_sd), .sweep_fail(a_sf)
  );

  codec_scheduler #(.SETTLE_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
    .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_r1),
    .rsp_valid(b_rv), .rsp_data(b_rd), .rsp_id(b_rid), .rsp_ready(b_rr),
    .codec_in(b_ci), .codec_out(b_co), .busy(b_busy),
    .sweep_start(b_ss), .sweep_done(b_sd), .sweep_fail(b_sf)
  );

  int pass_cnt = 0;
  int total    = 0;

  task automatic idle_inputs();
    a_v0 = 0; a_v1 = 0; a_d0 = 0; a_d1 = 0; a_rr = 0; a_ss = 0;
    b_v0 = 0; b_v1 = 0; b_d0 = 0; b_d1 = 0; b_rr = 0; b_ss = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic drain_a();
    a_v0 = 0; a_v1 = 0; a_rr = 1;
    for (int k = 0; k < 10; k++) begin
      if (!a_busy) break;
      @(negedge clk);
    end
    a_rr = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 0;
    #1;
    total++;
    if ({a_rv, a_rd, a_rid, a_ci, a_busy, a_sd, a_sf, a_r0, a_r1} !== 15'h0)
      $display("FAIL reset_a: got %b expected all zero",
               {a_rv, a_rd, a_rid, a_ci, a_busy, a_sd, a_sf, a_r0, a_r1});
    else pass_cnt++;
    total++;
    if ({b_rv, b_rd, b_rid, b_ci, b_busy, b_sd, b_sf, b_r0, b_r1} !== 15'h0)
      $display("FAIL reset_b: got %b expected all zero",
               {b_rv, b_rd, b_rid, b_ci, b_busy, b_sd, b_sf, b_r0, b_r1});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_single();
    @(negedge clk);
    a_v0 = 1; a_d0 = 4'b0101;
    #1;
    total++;
    if ({a_r0, a_r1} !== 2'b10) $display("FAIL single_ready: got %b expected 10", {a_r0, a_r1});
    else pass_cnt++;
    @(negedge clk);
    a_v0 = 0;
    total++;
    if ({a_rv, a_busy, a_ci} !== 6'b0_1_0101)
      $display("FAIL single_drive: got %b expected 010101", {a_rv, a_busy, a_ci});
    else pass_cnt++;
    @(negedge clk);
    total++;
    if ({a_rv, a_rd, a_rid} !== 6'b1_0101_0)
      $display("FAIL single_rsp: got %b expected 101010", {a_rv, a_rd, a_rid});
    else pass_cnt++;
    a_rr = 1;
    @(negedge clk);
    a_rr = 0;
    total++;
    if ({a_rv, a_busy} !== 2'b00) $display("FAIL single_done: got %b expected 00", {a_rv, a_busy});
    else pass_cnt++;
  endtask

  task automatic test_contention();
    int grants[$];
    int both_hi = 0;
    do_reset();
    a_v0 = 1; a_v1 = 1; a_d0 = 4'h3; a_d1 = 4'hC; a_rr = 1;
    for (int c = 0; c < 40 && grants.size() < 4; c++) begin
      #1;
      if (a_r0 && a_r1) both_hi++;
      if (a_r0) grants.push_back(0);
      if (a_r1) grants.push_back(1);
      @(negedge clk);
    end
    drain_a();
    total++;
    if (grants.size() != 4 || both_hi != 0)
      $display("FAIL contention_count: got %0d grants (%0d double) expected 4 (0)",
               grants.size(), both_hi);
    else pass_cnt++;
    for (int i = 0; i < grants.size(); i++) begin
      total++;
      if (grants[i] != i % 2) $display("FAIL contention_order[%0d]: got %0d expected %0d",
                                       i, grants[i], i % 2);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] d;
    int waited = 0;
    @(negedge clk);
    d = 4'($urandom);
    a_v1 = 1; a_d1 = d; a_rr = 0;
    @(negedge clk);
    a_v0 = 1;
    while (!a_rv && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (a_rv !== 1'b1) $display("FAIL bp_timeout: got rsp_valid %b expected 1", a_rv);
    else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if ({a_rv, a_rd, a_rid, a_r0, a_r1} !== {1'b1, d, 1'b1, 2'b00})
        $display("FAIL bp_hold[%0d]: got %b expected %b", k,
                 {a_rv, a_rd, a_rid, a_r0, a_r1}, {1'b1, d, 1'b1, 2'b00});
      else pass_cnt++;
      @(negedge clk);
    end
    a_v0 = 0; a_v1 = 0; a_rr = 1;
    @(negedge clk);
    a_rr = 0;
    total++;
    if (a_rv !== 1'b0) $display("FAIL bp_release: got %b expected 0", a_rv);
    else pass_cnt++;
  endtask

  task automatic test_settle3();
    logic [3:0] d;
    @(negedge clk);
    d = 4'($urandom);
    b_v0 = 1; b_d0 = d;
    #1;
    total++;
    if (b_r0 !== 1'b1) $display("FAIL settle3_ready: got %b expected 1", b_r0);
    else pass_cnt++;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      b_v0 = 0;
      total++;
      if (b_rv !== (k >= 4)) $display("FAIL settle3_lat[%0d]: got %b expected %b", k, b_rv, k >= 4);
      else pass_cnt++;
    end
    total++;
    if ({b_rd, b_rid} !== {d, 1'b0}) $display("FAIL settle3_data: got %b expected %b",
                                              {b_rd, b_rid}, {d, 1'b0});
    else pass_cnt++;
    b_rr = 1;
    @(negedge clk);
    b_rr = 0;
  endtask

  task automatic test_reset_mid_drive();
    int bad = 0;
    @(negedge clk);
    a_v0 = 1; a_d0 = 4'h9; b_v1 = 1; b_d1 = 4'h6;
    @(negedge clk);
    a_v0 = 0; b_v1 = 0;
    total++;
    if ({a_busy, a_rv, b_busy, b_rv} !== 4'b1010)
      $display("FAIL rstmid_pre: got %b expected 1010", {a_busy, a_rv, b_busy, b_rv});
    else pass_cnt++;
    #2 rst_n = 0;
    #1;
    total++;
    if ({a_rv, a_rd, a_rid, a_ci, a_busy, b_rv, b_rd, b_rid, b_ci, b_busy} !== 22'h0)
      $display("FAIL rstmid_now: got %b expected all zero",
               {a_rv, a_rd, a_rid, a_ci, a_busy, b_rv, b_rd, b_rid, b_ci, b_busy});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1; a_rr = 1; b_rr = 1;
    repeat (6) begin
      @(negedge clk);
      if ({a_rv, a_busy, b_rv, b_busy} !== 4'b0000) bad++;
    end
    a_rr = 0; b_rr = 0;
    total++;
    if (bad != 0) $display("FAIL rstmid_after: got %0d cycles with response expected 0", bad);
    else pass_cnt++;
  endtask

  // Pulses sweep_start on A (with both requests raised) and records the sweep.
  task automatic run_sweep(output logic [1:0] rdy, output int n_codes,
                           output int n_bad, output int n_done);
    logic [3:0] seen[$];
    @(negedge clk);
    a_ss = 1; a_v0 = 1; a_v1 = 1;
    #1 rdy = {a_r0, a_r1};
    @(negedge clk);
    a_ss = 0; a_v0 = 0; a_v1 = 0;
    n_done = 0;
    for (int c = 0; c < 24; c++) begin
      if (a_busy) seen.push_back(a_ci);
      if (a_sd) n_done++;
      @(negedge clk);
    end
    n_codes = seen.size();
    n_bad = 0;
    for (int i = 0; i < seen.size(); i++) if (seen[i] != 4'(i)) n_bad++;
  endtask

  task automatic test_sweep();
    logic [1:0] rdy;
    int n_codes, n_bad, n_done;
`ifdef CODEC_SCHEDULER_SWEEP_EN
    fault = 0;
    run_sweep(rdy, n_codes, n_bad, n_done);
    total++;
    if (rdy !== 2'b00) $display("FAIL sweep_priority: got readys %b expected 00", rdy);
    else pass_cnt++;
    total++;
    if (n_codes != 16 || n_bad != 0)
      $display("FAIL sweep_codes: got %0d codes (%0d out of order) expected 16 (0)", n_codes, n_bad);
    else pass_cnt++;
    total++;
    if (n_done != 1 || a_sf !== 1'b0)
      $display("FAIL sweep_pass: got done=%0d fail=%b expected 1 0", n_done, a_sf);
    else pass_cnt++;
    fault = 1;
    run_sweep(rdy, n_codes, n_bad, n_done);
    fault = 0;
    total++;
    if (n_done != 1 || a_sf !== 1'b1)
      $display("FAIL sweep_fault: got done=%0d fail=%b expected 1 1", n_done, a_sf);
    else pass_cnt++;
    run_sweep(rdy, n_codes, n_bad, n_done);
    total++;
    if (a_sf !== 1'b0) $display("FAIL sweep_clear: got fail=%b expected 0", a_sf);
    else pass_cnt++;
`else
    int bad = 0;
    @(negedge clk);
    a_ss = 1;
    @(negedge clk);
    a_ss = 0;
    repeat (20) begin
      if ({a_busy, a_sd, a_sf} !== 3'b000) bad++;
      @(negedge clk);
    end
    total++;
    if (bad != 0) $display("FAIL sweep_disabled: got %0d active cycles expected 0", bad);
    else pass_cnt++;
    rdy = 2'b00; n_codes = 0; n_bad = 0; n_done = 0;
`endif
  endtask

  // Timestamp model: a request accepted on posedge number acc answers
  // from posedge acc+S onward until the consumer takes it.
  task automatic test_random();
    localparam int S = 1;
    bit         pending = 0;
    bit         ptr = 1;
    bit         id = 0;
    bit         exp_rv, gv, g, v0, v1, rr;
    logic [3:0] code = 0, exp_ci = 0, d0, d1;
    int         acc = 0;
    do_reset();
    for (int cyc = 0; cyc < 300; cyc++) begin
      exp_rv = pending && (cyc >= acc + S);
      v0 = ($urandom_range(0, 9) < 6);
      v1 = ($urandom_range(0, 9) < 6);
      rr = $urandom_range(0, 1) == 1;
      d0 = 4'($urandom); d1 = 4'($urandom);
      a_v0 = v0; a_v1 = v1; a_d0 = d0; a_d1 = d1; a_rr = rr;
      gv = !pending && (v0 || v1);
      g  = (v0 && v1) ? !ptr : v1;
      #1;
      total++;
      if ({a_rv, a_busy, a_ci, a_r0, a_r1} !== {exp_rv, pending, exp_ci, gv && !g, gv && g})
        $display("FAIL random_ctl[%0d]: got %b expected %b", cyc,
                 {a_rv, a_busy, a_ci, a_r0, a_r1}, {exp_rv, pending, exp_ci, gv && !g, gv && g});
      else pass_cnt++;
      if (exp_rv) begin
        total++;
        if ({a_rd, a_rid} !== {code, id})
          $display("FAIL random_rsp[%0d]: got %b expected %b", cyc, {a_rd, a_rid}, {code, id});
        else pass_cnt++;
      end
      if (gv) begin
        pending = 1; acc = cyc + 1; code = g ? d1 : d0; id = g; exp_ci = code;
      end else if (exp_rv && rr) begin
        pending = 0; ptr = id;
      end
      @(negedge clk);
    end
    drain_a();
  endtask

  initial begin
    fault = 0;
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_settle3();
    test_reset_mid_drive();
    test_sweep();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end
endmodule
